// File: rtl/ahb_mem_responder.sv
// AHB-Lite word-addressed data memory responder with programmable wait states.
// Define AHB_RESP_ERR_EN to enable ERROR responses for out-of-range addresses.
module ahb_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [DATA_W-1:0] HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    // state | meaning
    // IDLE  | no data phase pending, ready
    // WAIT  | inserting wait states before an OKAY data phase
    // DATA  | OKAY data phase completing this cycle
    // ERR1  | first ERROR cycle, not ready
    // ERR2  | second ERROR cycle, ready
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
`ifdef AHB_RESP_ERR_EN
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;
`endif
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              out_of_range;
    logic              unused_bits;

`ifdef AHB_RESP_ERR_EN
    // DEPTH is a power of two, so any set bit above the index field is out of range
    assign out_of_range = |HADDR[ADDR_W-1:2+IDX_W];
    assign HRESP        = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign unused_bits  = ^{HADDR[1:0], HTRANS[0]};
    assign HREADYOUT    = (state_q != ST_WAIT) && (state_q != ST_ERR1);
`else
    assign out_of_range = 1'b0;
    assign HRESP        = 1'b0;
    assign unused_bits  = ^{HADDR[ADDR_W-1:2+IDX_W], HADDR[1:0], HTRANS[0]};
    assign HREADYOUT    = (state_q != ST_WAIT);
`endif

    assign accept = HSEL && HTRANS[1] && HREADYOUT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        if (state_q == ST_WAIT) begin
            if (cnt_q == 4'd0) begin
                state_d = ST_DATA;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
`ifdef AHB_RESP_ERR_EN
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
`endif
        end else if (accept) begin
            idx_d   = HADDR[2 +: IDX_W];
            write_d = HWRITE;
            if (out_of_range) begin
`ifdef AHB_RESP_ERR_EN
                state_d = ST_ERR1;
`endif
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WS_LOAD;
            end else begin
                state_d = ST_DATA;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
        end
    end

    // Array is deliberately not reset; a write still in flight at reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_DATA) && write_q) begin
            mem[idx_q] <= HWDATA;
        end
    end

    assign HRDATA = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) against a
// word-array reference model, directed scenarios plus randomized transfers.
module tb_ahb_mem_responder;

    localparam int NI = 3;
    localparam int WSV [NI] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel   [NI];
    logic [31:0] haddr  [NI];
    logic [1:0]  htrans [NI];
    logic        hwrite [NI];
    logic [31:0] hwdata [NI];
    logic        hready [NI];
    logic        hresp  [NI];
    logic [31:0] hrdata [NI];

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [NI][1024];
    bit          ref_vld [NI][1024];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } op_t;
    op_t ops[$];

    always #5 clk = ~clk;

    ahb_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HREADYOUT(hready[0]), .HRESP(hresp[0]),
        .HRDATA(hrdata[0]));
    ahb_mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HREADYOUT(hready[1]), .HRESP(hresp[1]),
        .HRDATA(hrdata[1]));
    ahb_mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
        .HWRITE(hwrite[2]), .HWDATA(hwdata[2]), .HREADYOUT(hready[2]), .HRESP(hresp[2]),
        .HRDATA(hrdata[2]));

    function automatic bit is_err(logic [31:0] addr);
`ifdef AHB_RESP_ERR_EN
        return (addr >> 2) >= 1024;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(logic [31:0] addr);
        return int'((addr >> 2) % 1024);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_idle(int k);
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
    endtask

    // One isolated transfer; entered and left just after a rising edge
    task automatic xfer(int k, bit wr, logic [31:0] addr, logic [31:0] wd);
        bit err;
        int nw;
        int ix;
        err = is_err(addr);
        nw  = err ? 1 : WSV[k];
        ix  = widx(addr);
        hsel[k] = 1'b1; htrans[k] = 2'b10; haddr[k] = addr; hwrite[k] = wr;
        @(posedge clk); #1;
        go_idle(k);
        hwdata[k] = wd;
        haddr[k]  = $urandom;
        hwrite[k] = 1'($urandom_range(0, 1));
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            chk("wait_ready", 32'(hready[k]), 32'd0);
            chk("wait_resp", 32'(hresp[k]), 32'(err));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("done_ready", 32'(hready[k]), 32'd1);
        chk("done_resp", 32'(hresp[k]), 32'(err));
        if (err || wr) chk("done_rdata_zero", hrdata[k], 32'd0);
        else if (ref_vld[k][ix]) chk("read_data", hrdata[k], ref_mem[k][ix]);
        if (wr && !err) begin
            ref_mem[k][ix] = wd;
            ref_vld[k][ix] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    // Back-to-back transfers from the ops queue; only for the zero-wait instance
    task automatic pipe(int k);
        int n;
        int ix;
        n = ops.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel[k] = 1'b1; htrans[k] = 2'b10;
                haddr[k] = ops[i].addr; hwrite[k] = ops[i].wr;
            end else begin
                go_idle(k);
            end
            if (i > 0) hwdata[k] = ops[i-1].wd;
            @(negedge clk);
            chk("pipe_ready", 32'(hready[k]), 32'd1);
            chk("pipe_resp", 32'(hresp[k]), 32'd0);
            if (i == 0) chk("pipe_idle_rdata", hrdata[k], 32'd0);
            else begin
                ix = widx(ops[i-1].addr);
                if (ops[i-1].wr) begin
                    chk("pipe_wr_rdata", hrdata[k], 32'd0);
                    ref_mem[k][ix] = ops[i-1].wd;
                    ref_vld[k][ix] = 1'b1;
                end else if (ref_vld[k][ix]) begin
                    chk("pipe_read", hrdata[k], ref_mem[k][ix]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = 2'b00; hwrite[k] = 1'b0; hwdata[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", 32'(hready[k]), 32'd1);
            chk("rst_resp", 32'(hresp[k]), 32'd0);
            chk("rst_rdata", hrdata[k], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) chk("idle_ready", 32'(hready[k]), 32'd1);
            @(posedge clk); #1;
        end

        // One wait state: write then read back
        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF);
        xfer(1, 1'b0, 32'h10, 32'h0);
        chk("ws1_model_word", ref_mem[1][4], 32'hDEADBEEF);

        // Zero wait states, pipelined, including read-after-write
        ops.delete();
        ops.push_back('{1'b1, 32'h0, 32'h1});
        ops.push_back('{1'b1, 32'h4, 32'h2});
        ops.push_back('{1'b1, 32'h8, 32'h3});
        ops.push_back('{1'b0, 32'h0, 32'h0});
        ops.push_back('{1'b0, 32'h4, 32'h0});
        ops.push_back('{1'b0, 32'h8, 32'h0});
        ops.push_back('{1'b1, 32'hC, 32'h55});
        ops.push_back('{1'b0, 32'hC, 32'h0});
        ops.push_back('{1'b1, 32'h4, 32'h77});
        ops.push_back('{1'b0, 32'h4, 32'h0});
        pipe(0);

        // Out-of-range: ERROR with the macro, wrap to word 0 without
        for (int k = 0; k < NI; k++) begin
            xfer(k, 1'b1, 32'h0, 32'hA5A50000 + 32'(k));
            xfer(k, 1'b0, 32'h1000, 32'h0);
            xfer(k, 1'b1, 32'h1000, 32'h12345670 + 32'(k));
            xfer(k, 1'b0, 32'h0, 32'h0);
        end

        // Reset during the second wait cycle drops the write
        xfer(2, 1'b1, 32'h20, 32'h0BADF00D);
        hsel[2] = 1'b1; htrans[2] = 2'b10; haddr[2] = 32'h20; hwrite[2] = 1'b1;
        @(posedge clk); #1;
        go_idle(2);
        hwdata[2] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("midwait_w1_ready", 32'(hready[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midwait_w2_ready", 32'(hready[2]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midwait_rst_ready", 32'(hready[2]), 32'd1);
        chk("midwait_rst_resp", 32'(hresp[2]), 32'd0);
        chk("midwait_rst_rdata", hrdata[2], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(2, 1'b0, 32'h20, 32'h0);

        // BUSY with HSEL, then NONSEQ without HSEL: neither may write
        xfer(1, 1'b1, 32'h30, 32'hC0FFEE00);
        for (int c = 0; c < 4; c++) begin
            hsel[1] = (c < 2); htrans[1] = (c < 2) ? 2'b01 : 2'b10;
            haddr[1] = 32'h30; hwrite[1] = 1'b1; hwdata[1] = 32'h11111111;
            @(negedge clk);
            chk("nox_ready", 32'(hready[1]), 32'd1);
            chk("nox_resp", 32'(hresp[1]), 32'd0);
            @(posedge clk); #1;
        end
        go_idle(1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h30, 32'h0);

        // Randomized isolated transfers on every instance, some aliasing past DEPTH
        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 30; t++) begin
                logic [31:0] a;
                a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
                if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
                xfer(k, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        // Randomized pipelined traffic on the zero-wait instance
        ops.delete();
        for (int t = 0; t < 30; t++) begin
            op_t o;
            o.wr   = 1'($urandom_range(0, 1));
            o.addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            o.wd   = $urandom;
            ops.push_back(o);
        end
        pipe(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_mem_responder.md
# ahb_mem_responder

AHB-Lite word-addressed memory responder: the subordinate end of the bus driven by the register-file stage's transfer controller (HTRANS/HWRITE/address/write data out, read data and ready in). It decodes address phases, inserts a configurable number of wait states, and services single-word reads and writes into an internal array. It also returns OKAY or two-cycle ERROR responses. It sits between the processor's memory port and the testbench/system memory map as the data memory.

## Interface
Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA/HRDATA width
- DEPTH, 1024, number of DATA_W words in the array (power of two)
- WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY data phase (0..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  byte address; bits [1:0] ignored
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 write, 0 read
- HWDATA  in  DATA_W  write data, valid in data phase
- HREADYOUT  out  1  data phase completes when high
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  DATA_W  read data, valid when HREADYOUT=1 in a read data phase

## Operation
- Word index = HADDR[2 +: log2(DEPTH)]; out-of-range = HADDR[ADDR_W-1:2] >= DEPTH.
- Address phase accepted at a rising edge when HSEL=1, HTRANS[1]=1, HREADYOUT=1. Captured: word index, HWRITE, range flag.
- IDLE/BUSY transfers, or HSEL=0: no transfer; zero-wait OKAY; HREADYOUT stays 1.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accept → WAIT if WAIT_STATES>0, else DATA; out-of-range → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 and decrements; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0. Completing cycle: read drives HRDATA = mem[idx] combinationally; write commits HWDATA to mem[idx] at end of cycle. A new address phase may be accepted in the same cycle (pipelined); next state is chosen as in IDLE, else → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No write; HRDATA=0. Address phase acceptance as in DATA.
- HRDATA=0 whenever not in a read DATA cycle.
- Back-to-back write then read of the same word returns the new data, because the write commits before the read's data phase.
- HWDATA, HWRITE and HADDR changes during WAIT/ERR1 are ignored (no acceptance while HREADYOUT=0).

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0. Array contents are not reset.
- rst asserted mid-transfer: IDLE at next edge; a pending write is dropped.
- Latency, accept at edge N: the data phase completes in cycle N+1+WAIT_STATES.
- Throughput: 1 transfer per WAIT_STATES+1 cycles; with WAIT_STATES=0, 1 per cycle.
- ERROR: always exactly 2 cycles (ERR1, ERR2), with no wait states added.

## Configuration
- AHB_RESP_ERR_EN defined: out-of-range addresses produce the ERR1/ERR2 ERROR response.
- AHB_RESP_ERR_EN undefined: no range check; the index wraps modulo DEPTH; HRESP is tied 0; the ERR states are absent.

## Test plan
- Reset: assert rst 2 cycles → HREADYOUT=1, HRESP=0, HRDATA=0. Then IDLE transfers for 5 cycles → HREADYOUT stays 1.
- WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10 → each data phase shows HREADYOUT 0 then 1; the read returns 0xDEADBEEF in its HREADYOUT=1 cycle.
- WAIT_STATES=0 pipelined: writes 0x1,0x2,0x3 to 0x0,0x4,0x8 on consecutive cycles, then reads the same addresses → 1 transfer per cycle; reads return 0x1,0x2,0x3; read-after-write of the same word returns the new data.
- AHB_RESP_ERR_EN, DEPTH=1024: read 0x1000 → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. A write to 0x1000 leaves mem[0] unchanged. Without the macro, a write to 0x1000 lands in mem[0].
- Reset mid-wait: start a write with WAIT_STATES=3, assert rst during the 2nd wait cycle → next cycle state is IDLE, HREADYOUT=1, and a subsequent read shows the word unmodified.
- BUSY/HSEL=0 with a valid address and HWRITE=1 → no write occurs, HREADYOUT=1, HRESP=0.
